// File: rtl/nubus_pkg.sv
// nubus_pkg: shared constants and state type for NuBus slot controllers
package nubus_pkg;
    localparam logic [3:0] SLOT_BASE       = 4'hF;
    localparam int         DEFAULT_TIMEOUT = 1023;
    localparam logic [7:0] REG_OFFSET      = 8'h08;
    localparam logic [3:0] ROM_OFFSET      = 4'hF;
    typedef enum logic [1:0] {IDLE, REQ, DONE, RECOVER} state_t;
endpackage

// File: rtl/nubus_timeout_ctr.sv
// nubus_timeout_ctr: clear/enable cycle counter with terminal-count flag
//   clk, reset_n : clock, async active-low reset
//   clr, en      : synchronous clear (wins), count enable
//   tc           : high while count == TIMEOUT_CYC-1
module nubus_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    end
    assign tc = count == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/nubus_slot_master.sv
// nubus_slot_master: 68000-to-NuBus slot initiator with timeout bus error and slot interrupt
//   cpu_*   : 68000 side (cs, as_n, rw, uds_n, lds_n, addr, dout in; din, dtack_n, berr_n out)
//   slot_*  : card side (addr, data_out, uds_lds, rw_n, select out; data_in, ack_n, nmrq_n in)
//   irq_enable / slot_irq : interrupt gate and registered request
module nubus_slot_master
    import nubus_pkg::*;
#(
    parameter logic [3:0] SLOT_ID     = 4'hE,
    parameter int         TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_cs,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    input  logic        irq_enable,
    output logic        slot_irq,
    output logic [31:0] slot_addr,
    output logic [15:0] slot_data_out,
    input  logic [15:0] slot_data_in,
    output logic [1:0]  slot_uds_lds,
    output logic        slot_rw_n,
    output logic        slot_select,
    input  logic        slot_ack_n,
    input  logic        slot_nmrq_n
);
    state_t state, state_nx;
    logic start, tmo_en, tmo_tc, fin_ack, fin_tmo, rel;

    nubus_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk(clk), .reset_n(reset_n), .clr(start), .en(tmo_en), .tc(tmo_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // a stale ack (still low from the previous card cycle) blocks a new start
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        tmo_en   = 1'b0;
        fin_ack  = 1'b0;
        fin_tmo  = 1'b0;
        rel      = 1'b0;
        case (state)
            IDLE: if (cpu_cs && !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && slot_ack_n) begin
                start    = 1'b1;
                state_nx = REQ;
            end
            REQ: if (!slot_ack_n) begin
                fin_ack  = 1'b1;
                state_nx = DONE;
            end else if (tmo_tc) begin
                fin_tmo  = 1'b1;
                state_nx = DONE;
            end else tmo_en = 1'b1;
            DONE: if (cpu_as_n) begin
                rel      = 1'b1;
                state_nx = RECOVER;
            end
            RECOVER: if (slot_ack_n) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request fields are latched once at start so the card sees them stable for the whole select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_select   <= 1'b0;
            slot_addr     <= '0;
            slot_data_out <= '0;
            slot_uds_lds  <= '0;
            slot_rw_n     <= 1'b1;
            cpu_din       <= '0;
            cpu_dtack_n   <= 1'b1;
            cpu_berr_n    <= 1'b1;
            slot_irq      <= 1'b0;
        end else begin
            slot_irq <= ~slot_nmrq_n & irq_enable;
            if (start) begin
                slot_select   <= 1'b1;
                slot_addr     <= {SLOT_BASE, SLOT_ID, cpu_addr, 1'b0};
                slot_uds_lds  <= {~cpu_uds_n, ~cpu_lds_n};
                slot_rw_n     <= cpu_rw;
                slot_data_out <= cpu_dout;
            end
            if (fin_ack || fin_tmo) slot_select <= 1'b0;
            if (fin_ack && slot_rw_n) cpu_din <= slot_data_in;
            if (fin_ack) cpu_dtack_n <= 1'b0;
            if (fin_tmo) cpu_berr_n <= 1'b0;
            if (rel) begin
                cpu_dtack_n <= 1'b1;
                cpu_berr_n  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nubus_slot_master.sv
// tb_nubus_slot_master: randomized self-checking bench with a behavioural card and CPU model
module tb_nubus_slot_master;
    import nubus_pkg::*;
    localparam int TO = 16;
    logic clk = 1'b0, reset_n = 1'b0;
    logic cpu_cs = 1'b0, cpu_as_n = 1'b1, cpu_rw = 1'b1, cpu_uds_n = 1'b1, cpu_lds_n = 1'b1;
    logic [22:0] cpu_addr = '0;
    logic [15:0] cpu_dout = '0, cpu_din, slot_data_out, slot_data_in = '0;
    logic cpu_dtack_n, cpu_berr_n, slot_irq, slot_rw_n, slot_select;
    logic irq_enable = 1'b0, slot_ack_n = 1'b1, slot_nmrq_n = 1'b1;
    logic [31:0] slot_addr;
    logic [1:0] slot_uds_lds;
    int n_checks = 0, n_fail = 0;
    int ack_dly = 0, ack_hold = 0, sel_run = 0, hold_cnt = 0, hold_lim = 0;
    logic [15:0] card_data = '0, mdl_din = '0;

    nubus_slot_master #(.SLOT_ID(4'hE), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_cs(cpu_cs), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
        .irq_enable(irq_enable), .slot_irq(slot_irq), .slot_addr(slot_addr),
        .slot_data_out(slot_data_out), .slot_data_in(slot_data_in), .slot_uds_lds(slot_uds_lds),
        .slot_rw_n(slot_rw_n), .slot_select(slot_select), .slot_ack_n(slot_ack_n),
        .slot_nmrq_n(slot_nmrq_n)
    );

    always #5 clk = ~clk;

    // card: acks after ack_dly select cycles (0 = never), keeps ack low hold_lim cycles after select drops
    always @(negedge clk) begin
        if (slot_select) begin
            sel_run++;
            hold_cnt = 0;
            hold_lim = ack_hold;
            if (ack_dly != 0 && sel_run == ack_dly) begin
                slot_ack_n = 1'b0;
                slot_data_in = card_data;
            end
        end else begin
            sel_run = 0;
            if (!slot_ack_n) begin
                if (hold_cnt >= hold_lim) slot_ack_n = 1'b1;
                else hold_cnt++;
            end
        end
    end

    // CPU: holds AS until DTACK/BERR seen twice (or abandons at cycle 'abandon'), reports what it observed
    task automatic cpu_cycle(input logic rd, input logic [22:0] a, input logic [15:0] wd,
                             input logic [1:0] ln, input int dly, input int hold, input int abandon,
                             input logic [15:0] cd, output int sel_len, output int dt, output int be,
                             output logic stable, output logic overlap, output logic done,
                             output logic [31:0] obs_addr);
        logic prev_sel, prev_ack, raised;
        logic [31:0] ea;
        ea = {SLOT_BASE, 4'hE, a, 1'b0};
        ack_dly = dly; ack_hold = hold; card_data = cd;
        cpu_cs = 1'b1; cpu_as_n = 1'b0; cpu_rw = rd; cpu_uds_n = ~ln[1]; cpu_lds_n = ~ln[0];
        cpu_addr = a; cpu_dout = wd;
        sel_len = 0; dt = 0; be = 0; stable = 1'b1; overlap = 1'b0; done = 1'b0; raised = 1'b0;
        obs_addr = '0;
        prev_sel = slot_select; prev_ack = slot_ack_n;
        for (int c = 1; c <= 400 && !done; c++) begin
            @(negedge clk); #1;
            if (slot_select && !prev_sel && !prev_ack) overlap = 1'b1;
            if (slot_select) begin
                sel_len++;
                obs_addr = slot_addr;
                if (slot_addr !== ea || slot_uds_lds !== ln || slot_rw_n !== rd ||
                    (!rd && slot_data_out !== wd)) stable = 1'b0;
            end
            if (!cpu_dtack_n) dt++;
            if (!cpu_berr_n) be++;
            if (raised && cpu_dtack_n && cpu_berr_n && dt + be > 0) done = 1'b1;
            else if (!raised && (c == abandon || dt == 2 || be == 2)) begin
                cpu_as_n = 1'b1; cpu_cs = 1'b0; raised = 1'b1;
            end
            prev_sel = slot_select; prev_ack = slot_ack_n;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({slot_select, slot_addr, slot_data_out, slot_uds_lds, slot_rw_n} !== {1'b0, 32'h0, 16'h0, 2'b00, 1'b1}) begin n_fail++; $display("FAIL reset_slot got %h want %h", {slot_select, slot_addr, slot_data_out, slot_uds_lds, slot_rw_n}, {1'b0, 32'h0, 16'h0, 2'b00, 1'b1}); end
        n_checks++; if ({cpu_din, cpu_dtack_n, cpu_berr_n, slot_irq} !== {16'h0, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_cpu got %h want %h", {cpu_din, cpu_dtack_n, cpu_berr_n, slot_irq}, {16'h0, 1'b1, 1'b1, 1'b0}); end
        @(negedge clk);
        reset_n = 1'b1;
        mdl_din = '0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int sl, dt, be; logic st, ov, dn; logic [31:0] oa;
        cpu_cycle(1'b1, {REG_OFFSET, 15'h0}, 16'h0, 2'b11, 3, 0, 0, 16'h0003, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h0003;
        n_checks++; if (oa !== 32'hFE080000) begin n_fail++; $display("FAIL read_addr got %h want %h", oa, 32'hFE080000); end
        n_checks++; if (sl !== 3) begin n_fail++; $display("FAIL read_sel_len got %0d want 3", sl); end
        n_checks++; if (cpu_din !== mdl_din) begin n_fail++; $display("FAIL read_din got %h want %h", cpu_din, mdl_din); end
        n_checks++; if (dt !== 2 || be !== 0 || dn !== 1'b1) begin n_fail++; $display("FAIL read_strobes got dt=%0d be=%0d done=%0b want 2 0 1", dt, be, dn); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL read_stable got %0b want 1", st); end
    endtask

    task automatic test_write();
        int sl, dt, be; logic st, ov, dn; logic [31:0] oa; logic [22:0] a;
        a = {ROM_OFFSET, 19'h00010};
        cpu_cycle(1'b0, a, 16'hA55A, 2'b10, 4, 0, 0, 16'h1234, sl, dt, be, st, ov, dn, oa);
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL write_held got %0b want 1", st); end
        n_checks++; if (oa !== {8'hFE, ROM_OFFSET, 19'h00010, 1'b0}) begin n_fail++; $display("FAIL write_addr got %h want %h", oa, {8'hFE, ROM_OFFSET, 19'h00010, 1'b0}); end
        n_checks++; if (sl !== 4 || dt !== 2 || be !== 0) begin n_fail++; $display("FAIL write_cycle got sel=%0d dt=%0d be=%0d want 4 2 0", sl, dt, be); end
        n_checks++; if (cpu_din !== mdl_din) begin n_fail++; $display("FAIL write_din_kept got %h want %h", cpu_din, mdl_din); end
    endtask

    task automatic test_timeout();
        int sl, dt, be; logic st, ov, dn; logic [31:0] oa;
        cpu_cycle(1'b1, 23'h000100, 16'h0, 2'b01, 0, 0, 0, 16'hBEEF, sl, dt, be, st, ov, dn, oa);
        n_checks++; if (sl !== TO) begin n_fail++; $display("FAIL tmo_sel_len got %0d want %0d", sl, TO); end
        n_checks++; if (be !== 2 || dt !== 0 || dn !== 1'b1) begin n_fail++; $display("FAIL tmo_strobes got be=%0d dt=%0d done=%0b want 2 0 1", be, dt, dn); end
        n_checks++; if (cpu_din !== mdl_din) begin n_fail++; $display("FAIL tmo_din got %h want %h", cpu_din, mdl_din); end
        cpu_cycle(1'b1, 23'h000102, 16'h0, 2'b11, 2, 0, 0, 16'h5150, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h5150;
        n_checks++; if (dt !== 2 || be !== 0 || cpu_din !== mdl_din) begin n_fail++; $display("FAIL tmo_next got dt=%0d be=%0d din=%h want 2 0 %h", dt, be, cpu_din, mdl_din); end
        cpu_cycle(1'b1, 23'h000104, 16'h0, 2'b11, TO, 0, 0, 16'h7777, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h7777;
        n_checks++; if (sl !== TO || dt !== 2 || be !== 0 || cpu_din !== mdl_din) begin n_fail++; $display("FAIL ack_at_limit got sel=%0d dt=%0d be=%0d din=%h want %0d 2 0 %h", sl, dt, be, cpu_din, TO, mdl_din); end
    endtask

    task automatic test_stale_ack();
        int sl, dt, be; logic st, ov, dn; logic [31:0] oa;
        cpu_cycle(1'b1, 23'h000200, 16'h0, 2'b11, 2, 5, 0, 16'h1111, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h1111;
        cpu_cycle(1'b1, 23'h000202, 16'h0, 2'b11, 1, 0, 0, 16'h2222, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h2222;
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL stale_select_during_ack got %0b want 0", ov); end
        n_checks++; if (dn !== 1'b1 || sl !== 1 || cpu_din !== mdl_din) begin n_fail++; $display("FAIL stale_next got done=%0b sel=%0d din=%h want 1 1 %h", dn, sl, cpu_din, mdl_din); end
    endtask

    task automatic test_abandon();
        int sl, dt, be; logic st, ov, dn; logic [31:0] oa;
        cpu_cycle(1'b1, 23'h000300, 16'h0, 2'b11, 10, 0, 3, 16'h3C3C, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h3C3C;
        n_checks++; if (sl !== 10) begin n_fail++; $display("FAIL abandon_sel_len got %0d want 10", sl); end
        n_checks++; if (dt !== 1 || be !== 0 || dn !== 1'b1) begin n_fail++; $display("FAIL abandon_dtack got dt=%0d be=%0d done=%0b want 1 0 1", dt, be, dn); end
        n_checks++; if (cpu_din !== mdl_din) begin n_fail++; $display("FAIL abandon_din got %h want %h", cpu_din, mdl_din); end
    endtask

    task automatic test_irq();
        logic n, e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            n = (i < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            e = (i == 1) ? 1'b1 : ((i < 3) ? 1'b0 : 1'($urandom_range(0, 1)));
            slot_nmrq_n = n; irq_enable = e;
            @(negedge clk); #1;
            n_checks++; if (slot_irq !== (~n & e)) begin n_fail++; $display("FAIL irq step %0d got %0b want %0b", i, slot_irq, ~n & e); end
        end
        slot_nmrq_n = 1'b1; irq_enable = 1'b0;
    endtask

    task automatic test_random();
        int sl, dt, be, dly, hold; logic st, ov, dn, rd, tmo; logic [31:0] oa;
        logic [22:0] a; logic [15:0] wd, cd; logic [1:0] ln;
        for (int i = 0; i < 10; i++) begin
            rd = 1'($urandom_range(0, 1)); a = 23'($urandom); wd = 16'($urandom); cd = 16'($urandom);
            ln = 2'($urandom_range(1, 3)); dly = $urandom_range(1, TO + 4); hold = $urandom_range(0, 3);
            tmo = dly > TO;
            cpu_cycle(rd, a, wd, ln, dly, hold, 0, cd, sl, dt, be, st, ov, dn, oa);
            if (rd && !tmo) mdl_din = cd;
            n_checks++; if (sl !== (tmo ? TO : dly)) begin n_fail++; $display("FAIL rand%0d_sel_len got %0d want %0d", i, sl, tmo ? TO : dly); end
            n_checks++; if (dt !== (tmo ? 0 : 2) || be !== (tmo ? 2 : 0) || dn !== 1'b1) begin n_fail++; $display("FAIL rand%0d_strobes got dt=%0d be=%0d done=%0b want %0d %0d 1", i, dt, be, dn, tmo ? 0 : 2, tmo ? 2 : 0); end
            n_checks++; if (st !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL rand%0d_fields got stable=%0b overlap=%0b want 1 0", i, st, ov); end
            n_checks++; if (cpu_din !== mdl_din) begin n_fail++; $display("FAIL rand%0d_din got %h want %h", i, cpu_din, mdl_din); end
        end
    endtask

    task automatic test_reset_mid();
        int sl, dt, be; logic st, ov, dn, seen; logic [31:0] oa;
        ack_dly = 0; seen = 1'b0;
        cpu_cs = 1'b1; cpu_as_n = 1'b0; cpu_rw = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_addr = 23'h000400;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); #1; seen = slot_select; end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_req_select got %0b want 1", seen); end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (slot_select !== 1'b0 || cpu_dtack_n !== 1'b1 || cpu_berr_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req got sel=%0b dtack=%0b berr=%0b want 0 1 1", slot_select, cpu_dtack_n, cpu_berr_n); end
        @(negedge clk);
        cpu_as_n = 1'b1; cpu_cs = 1'b0; reset_n = 1'b1; mdl_din = '0;
        @(negedge clk); #1;
        ack_dly = 2; card_data = 16'h9999; seen = 1'b0;
        cpu_cs = 1'b1; cpu_as_n = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); #1; seen = !cpu_dtack_n; end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_done_dtack got %0b want 1", seen); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (cpu_dtack_n !== 1'b1 || cpu_din !== 16'h0) begin n_fail++; $display("FAIL rst_mid_done got dtack=%0b din=%h want 1 0000", cpu_dtack_n, cpu_din); end
        @(negedge clk);
        cpu_as_n = 1'b1; cpu_cs = 1'b0; reset_n = 1'b1;
        @(negedge clk); #1;
        cpu_cycle(1'b1, 23'h000406, 16'h0, 2'b11, 2, 0, 0, 16'h4242, sl, dt, be, st, ov, dn, oa);
        mdl_din = 16'h4242;
        n_checks++; if (dn !== 1'b1 || dt !== 2 || cpu_din !== mdl_din) begin n_fail++; $display("FAIL rst_recover got done=%0b dt=%0d din=%h want 1 2 %h", dn, dt, cpu_din, mdl_din); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_stale_ack();
        test_abandon();
        test_irq();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/nubus_slot_master.md
Name: nubus_slot_master

Overview:
- CPU-side initiator for the NuBus expansion slot interface.
- Converts 68000 bus cycles that the top-level address decoder steers to the slot window into select/ack_n handshakes toward the slot card, e.g. the video card.
- Returns read data and DTACK to the CPU.
- Signals bus error if the card never acknowledges.
- Registers and gates the card's nmrq_n into a CPU interrupt request.

Parameters:
- SLOT_ID, 4'hE, slot nibble placed in slot_addr[27:24].
- TIMEOUT_CYC, 1023, clk cycles from select assertion to bus-error abort.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_cs  in  1  decoded slot-window hit from top-level; qualifies cpu_as_n.
- cpu_as_n  in  1  68000 address strobe.
- cpu_rw  in  1  1=read, 0=write.
- cpu_uds_n  in  1  upper data strobe.
- cpu_lds_n  in  1  lower data strobe.
- cpu_addr  in  23  CPU word address A[23:1] within the slot window.
- cpu_dout  in  16  CPU write data.
- cpu_din  out  16  read data to CPU.
- cpu_dtack_n  out  1  data acknowledge.
- cpu_berr_n  out  1  bus error on timeout.
- irq_enable  in  1  slot interrupt enable.
- slot_irq  out  1  registered active-high slot interrupt.
- slot_addr  out  32  byte address to card.
- slot_data_out  out  16  write data to card.
- slot_data_in  in  16  read data from card.
- slot_uds_lds  out  2  active-high byte lanes {upper, lower}.
- slot_rw_n  out  1  1=read.
- slot_select  out  1  card select.
- slot_ack_n  in  1  card acknowledge, active-low.
- slot_nmrq_n  in  1  card interrupt, active-low.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: slot_select=0, slot_addr=0, slot_data_out=0, slot_uds_lds=0, slot_rw_n=1, cpu_din=0, cpu_dtack_n=1, cpu_berr_n=1, slot_irq=0, state IDLE, timeout counter 0.
- Address mapping: slot_addr = {4'hF, SLOT_ID, cpu_addr, 1'b0}.
- Lane mapping: slot_uds_lds = {~cpu_uds_n, ~cpu_lds_n}.
- Latching: address, lanes, rw and write data are registered at request start and held constant for the whole select period, because the card decodes addr while select is high.
- IDLE:
  - Start condition: cpu_cs & ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n) & slot_ack_n.
  - On start: latch fields, slot_select<=1, counter<=0, go to REQ.
  - If slot_ack_n=0 (stale ack from a previous cycle), do not start.
- REQ:
  - Hold select; counter increments each cycle.
  - On slot_ack_n=0: capture cpu_din<=slot_data_in (reads only; writes leave cpu_din unchanged), slot_select<=0, cpu_dtack_n<=0, go to DONE.
  - If counter reaches TIMEOUT_CYC-1 with no ack: slot_select<=0, cpu_berr_n<=0, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- Latency: the card's first ack is no earlier than 1 cycle after select. DTACK asserts the cycle after ack is sampled.
- DONE:
  - Hold cpu_dtack_n or cpu_berr_n low until cpu_as_n=1, then release both to 1 and go to RECOVER.
  - The CPU abandons a cycle by raising cpu_as_n; in REQ the block keeps select high until ack or timeout, since a card write cannot be aborted.
  - For an abandoned cycle, DONE sees cpu_as_n=1 immediately, so the strobe pulses for 1 cycle and is ignored by the CPU.
- RECOVER: wait for slot_ack_n=1, then go to IDLE. No new select is issued before the card has released ack.
- Back-to-back cycles: minimum 1 IDLE cycle between selects.
- Interrupt: slot_irq <= ~slot_nmrq_n & irq_enable each cycle; it is a level, and clearing is done by software at the card.
- Async reset mid-REQ drops select immediately; the card recovers because it releases ack when select=0.

Decomposition:
- Shared package nubus_pkg:
  - slot base nibble 4'hF.
  - State enum {IDLE, REQ, DONE, RECOVER}.
  - Default timeout constant.
  - Offsets for the card register window (8'h08) and ROM window (4'hF), for bench use.
- Sub-module nubus_timeout_ctr:
  - Clear/enable counter with terminal-count flag.
  - Width $clog2(TIMEOUT_CYC+1).
  - Shared with future slot controllers.

Test Plan:
- Read at cpu_addr 23'h040000 (slot_addr 32'hFE080000), card acks after 3 cycles with data 16'h0003 -> select high 3 cycles, cpu_din=16'h0003, DTACK low until cpu_as_n rises.
- Write 16'hA55A, only cpu_uds_n low -> slot_uds_lds=2'b10, slot_data_out=16'hA55A held throughout select, slot_rw_n=0, DTACK once.
- Card never acks, TIMEOUT_CYC=16 -> select drops after 16 cycles, cpu_berr_n low, DTACK stays 1, next cycle proceeds normally.
- Card holds ack_n low 5 cycles after select drops -> next CPU request waits in RECOVER/IDLE; no select until ack_n=1.
- cpu_as_n raised while in REQ, card acks at cycle 10 -> select held until ack, 1-cycle DTACK, returns to IDLE cleanly.
- slot_nmrq_n=0 with irq_enable toggled 0/1/0; reset_n pulsed low mid-REQ -> slot_irq follows enable one cycle later; reset drops select and dtack asynchronously.
